// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA constant generator slice.
package rsa_pkg;

  parameter int RSA_WIDTH = 8;

  typedef enum logic [1:0] {
    CG_IDLE,
    CG_CALC,
    CG_FIN
  } cg_state_t;

endpackage

// File: rtl/rsa_mod_double.sv
// Combinational modular doubling: r2 = 2*r mod p, assuming r < p.
module rsa_mod_double #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] r2_o
);

  logic [WIDTH-1:0] t_lo;
  logic             ge;

  // The carried-out MSB alone guarantees 2r >= p; the result fits in WIDTH bits.
  assign t_lo = {r_i[WIDTH-2:0], 1'b0};
  assign ge   = r_i[WIDTH-1] | (t_lo >= p_i);
  assign r2_o = ge ? (t_lo - p_i) : t_lo;

endmodule

// File: rtl/rsa_const_gen.sv
// Montgomery constant 2^(2*WIDTH) mod P by repeated modular doubling.
// Optional RSA_CONST_PCHECK_EN rejects zero/even moduli with err.
module rsa_const_gen
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] p_in,
  output logic             busy,
  output logic             done,
  output logic             const_valid,
  output logic [WIDTH-1:0] const_out,
  output logic             err
);

  localparam int CW = $clog2(2*WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(2*WIDTH - 1);

  cg_state_t        state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] const_q, const_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] r_dbl;
  logic             p_bad;

  rsa_mod_double #(.WIDTH(WIDTH)) u_dbl (
    .r_i (r_q),
    .p_i (p_q),
    .r2_o(r_dbl)
  );

`ifdef RSA_CONST_PCHECK_EN
  assign p_bad = (p_in == '0) || !p_in[0];
`else
  assign p_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    p_d     = p_q;
    const_d = const_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    err_d   = err_q;
    if (clear) begin
      state_d = CG_IDLE;
      r_d     = '0;
      cnt_d   = '0;
      const_d = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        CG_IDLE: begin
          if (start) begin
            p_d     = p_in;
            cnt_d   = '0;
            valid_d = 1'b0;
            err_d   = 1'b0;
            if (p_bad) begin
              err_d   = 1'b1;
              done_d  = 1'b1;
              const_d = '0;
            end else begin
              r_d     = (p_in == WIDTH'(1)) ? '0 : WIDTH'(1);
              state_d = CG_CALC;
            end
          end
        end
        CG_CALC: begin
          r_d   = r_dbl;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = CG_FIN;
        end
        CG_FIN: begin
          const_d = r_q;
          done_d  = 1'b1;
          valid_d = 1'b1;
          state_d = CG_IDLE;
        end
        default: state_d = CG_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CG_IDLE;
      r_q     <= '0;
      p_q     <= '0;
      const_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      r_q     <= r_d;
      p_q     <= p_d;
      const_q <= const_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != CG_IDLE);
  assign done        = done_q;
  assign const_valid = valid_q;
  assign const_out   = const_q;
  assign err         = err_q;

endmodule

// File: tb/tb_rsa_const_gen.sv
// Self-checking bench for rsa_const_gen (WIDTH=8) with a result scoreboard.
module tb_rsa_const_gen;

  typedef struct {
    logic [7:0] cval;
    logic       err;
    logic       valid;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [7:0] p_in = '0;
  logic       busy, done, const_valid, err;
  logic [7:0] const_out;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rsa_const_gen #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .clear      (clear),
    .start      (start),
    .p_in       (p_in),
    .busy       (busy),
    .done       (done),
    .const_valid(const_valid),
    .const_out  (const_out),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [7:0] p);
    exp_t e;
`ifdef RSA_CONST_PCHECK_EN
    if (p == 8'd0 || !p[0]) begin
      e.cval = 8'd0; e.err = 1'b1; e.valid = 1'b0; e.lat = 0;
      return e;
    end
`endif
    e.cval  = (p == 8'd0) ? 8'd0 : 8'((32'd65536) % {24'd0, p});
    e.err   = 1'b0;
    e.valid = 1'b1;
    e.lat   = 17;
    return e;
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic issue(input logic [7:0] p);
    p_in  = p;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_calc(input logic [7:0] p, input string tag);
    exp_t e;
    int   n;
    sb.push_back(model(p));
    issue(p);
    checks++;
    if (busy !== (sb[$].lat != 0)) begin
      errors++;
      $display("FAIL %s busy after start: got %b want %b", tag, busy, sb[$].lat != 0);
    end
    p_in = ~p;
    wait_done(n);
    e = sb.pop_front();
    checks++;
    if (n !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", tag, n, e.lat);
    end
    checks++;
    if ({const_out, const_valid, err, busy} !== {e.cval, e.valid, e.err, 1'b0}) begin
      errors++;
      $display("FAIL %s result: got c=%0d v=%b e=%b b=%b want c=%0d v=%b e=%b b=0",
               tag, const_out, const_valid, err, busy, e.cval, e.valid, e.err);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s done pulse width: got %b want 0", tag, done);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, const_valid, err, const_out} !== 12'd0) begin
      errors++;
      $display("FAIL reset outputs: got %b want 0", {busy, done, const_valid, err, const_out});
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_table();
    logic [7:0] ps[6] = '{8'd251, 8'd187, 8'd255, 8'd3, 8'd1, 8'd200};
    logic [7:0] cs[6] = '{8'd25, 8'd86, 8'd1, 8'd1, 8'd0, 8'd136};
    for (int i = 0; i < 6; i++) begin
`ifndef RSA_CONST_PCHECK_EN
      checks++;
      if (model(ps[i]).cval !== cs[i]) begin
        errors++;
        $display("FAIL model P=%0d: got %0d want %0d", ps[i], model(ps[i]).cval, cs[i]);
      end
`endif
      run_calc(ps[i], $sformatf("P=%0d", ps[i]));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run_calc(8'($urandom_range(255, 2)) | 8'd1, "rand");
  endtask

  task automatic test_ena_toggle();
    int en_n = 0;
    int k = 0;
    issue(8'd251);
    while (!done && k < 80) begin
      ena = k[0];
      tick();
      if (ena) en_n++;
      k++;
    end
    checks++;
    if (en_n !== 17 || const_out !== 8'd25) begin
      errors++;
      $display("FAIL ena toggle: got %0d cycles c=%0d want 17 c=25", en_n, const_out);
    end
    ena = 1'b1;
    tick();
  endtask

  task automatic test_ignore_start();
    int n;
    issue(8'd251);
    repeat (5) tick();
    p_in  = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    checks++;
    if (n + 6 !== 17 || const_out !== 8'd25) begin
      errors++;
      $display("FAIL ignore start: got lat=%0d c=%0d want lat=17 c=25", n + 6, const_out);
    end
    tick();
  endtask

  task automatic test_clear();
    bit seen = 0;
    issue(8'd251);
    repeat (8) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if ({busy, done, const_valid, err, const_out} !== 12'd0) begin
      errors++;
      $display("FAIL clear outputs: got %b want 0", {busy, done, const_valid, err, const_out});
    end
    repeat (20) begin
      tick();
      if (done) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL clear no-done: got %b want 0", seen);
    end
    p_in  = 8'd187;
    start = 1'b1;
    clear = 1'b1;
    tick();
    start = 1'b0;
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start+clear: busy got %b want 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    run_calc(8'd251, "pre-rst");
    issue(8'd251);
    repeat (6) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, const_valid, err, const_out} !== 12'd0) begin
      errors++;
      $display("FAIL rst mid-calc: got %b want 0", {busy, done, const_valid, err, const_out});
    end
    tick();
    rst = 1'b0;
    tick();
    run_calc(8'd187, "post-rst");
  endtask

  initial begin
    test_reset();
    test_table();
    test_random();
    test_ena_toggle();
    test_ignore_start();
    test_clear();
    test_rst_mid();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
